ws2812b_frame_sequencer: RTL

Frame-level controller for the WS2812B NRZ bit encoder. On `start` it fetches LED_COUNT 24-bit GRB pixels from a pixel source and issues one encoder trigger per bit, MSB first, with contiguous bit periods. It then holds the line low for the latch interval and reports completion. It sits between the pixel frame buffer and the encoder. The top level drives the LED pin as encoder output AND `line_en`.

---
 rtl/ws2812b_frame_sequencer_pkg.sv | 20 ++
 rtl/ws2812b_pixel_shifter.sv | 60 ++++++
 rtl/ws2812b_frame_sequencer.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/ws2812b_frame_sequencer_pkg.sv
// Shared types and constants for the WS2812B frame sequencer and its pixel shifter.
// Timing defaults assume a 50 MHz clock driving a 1.25 us WS2812B bit period.
package ws2812b_frame_sequencer_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH0,
        S_SHIFT,
        S_LATCH
    } seq_state_e;

    localparam int PIXEL_WIDTH                   = 24;
    localparam int DEFAULT_BIT_PERIOD_CLK_COUNTS = 62;
    localparam int DEFAULT_LATCH_CLK_COUNTS      = 3000;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/ws2812b_pixel_shifter.sv
// Datapath for one frame: the active GRB shift register, a one-entry prefetch
// holding register with its full flag, and the bit-within-pixel counter.
module ws2812b_pixel_shifter
    import ws2812b_frame_sequencer_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load_first,
    input  logic                   shift_en,
    input  logic                   advance,
    input  logic                   capture,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   msb,
    output logic                   first_bit,
    output logic                   last_bit,
    output logic                   hold_full
);

    localparam int                   BIT_CNT_W      = $clog2(PIXEL_WIDTH);
    localparam logic [BIT_CNT_W-1:0] LAST_BIT_INDEX = BIT_CNT_W'(PIXEL_WIDTH - 1);

    logic [PIXEL_WIDTH-1:0] shift_reg;
    logic [PIXEL_WIDTH-1:0] hold_reg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   hold_full_q;

    // On a pixel boundary whose prefetch lands on the same edge, the incoming
    // word bypasses the holding register so the next bit starts without a gap.
    always_ff @(posedge clk) begin
        if (reset) begin
            shift_reg   <= '0;
            hold_reg    <= '0;
            bit_cnt     <= '0;
            hold_full_q <= 1'b0;
        end else if (load_first) begin
            shift_reg   <= pixel_data;
            bit_cnt     <= '0;
            hold_full_q <= 1'b0;
        end else if (advance) begin
            shift_reg   <= hold_full_q ? hold_reg : pixel_data;
            bit_cnt     <= '0;
            hold_full_q <= 1'b0;
        end else begin
            if (shift_en) begin
                shift_reg <= {shift_reg[PIXEL_WIDTH-2:0], 1'b0};
                bit_cnt   <= bit_cnt + BIT_CNT_W'(1);
            end
            if (capture) begin
                hold_reg    <= pixel_data;
                hold_full_q <= 1'b1;
            end
        end
    end

    assign msb       = shift_reg[PIXEL_WIDTH-1];
    assign first_bit = (bit_cnt == '0);
    assign last_bit  = (bit_cnt == LAST_BIT_INDEX);
    assign hold_full = hold_full_q;

endmodule

// File: rtl/ws2812b_frame_sequencer.sv
// Frame-level controller: fetches LED_COUNT GRB pixels, issues one encoder
// trigger per bit with contiguous periods, then holds the line low to latch.
module ws2812b_frame_sequencer
    import ws2812b_frame_sequencer_pkg::*;
#(
    parameter int LED_COUNT             = 8,
    parameter int BIT_PERIOD_CLK_COUNTS = DEFAULT_BIT_PERIOD_CLK_COUNTS,
    parameter int LATCH_CLK_COUNTS      = DEFAULT_LATCH_CLK_COUNTS,
    localparam int ADDR_W               = (LED_COUNT > 1) ? $clog2(LED_COUNT) : 1
)
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic                   underrun,
    output logic                   pixel_req,
    output logic [ADDR_W-1:0]      pixel_addr,
    input  logic                   pixel_valid,
    input  logic [PIXEL_WIDTH-1:0] pixel_data,
    output logic                   bit_trigger,
    output logic                   bit_to_code,
    output logic                   line_en
);

    localparam int                CNT_W         = $clog2(max_int(BIT_PERIOD_CLK_COUNTS, LATCH_CLK_COUNTS) + 1);
    localparam logic [CNT_W-1:0]  PERIOD_RELOAD = CNT_W'(BIT_PERIOD_CLK_COUNTS - 1);
    localparam logic [CNT_W-1:0]  LATCH_RELOAD  = CNT_W'(LATCH_CLK_COUNTS);
    localparam logic [ADDR_W-1:0] LAST_INDEX    = ADDR_W'(LED_COUNT - 1);

    seq_state_e        state;
    seq_state_e        state_next;
    logic [CNT_W-1:0]  period_cnt;
    logic [ADDR_W-1:0] pixel_index;
    logic              prefetch_req;
    logic              underrun_q;
    logic              line_en_q;

    logic start_accept;
    logic load_first;
    logic shift_en;
    logic advance;
    logic capture;
    logic enter_latch;
    logic set_underrun;
    logic trigger;
    logic period_end;
    logic more_pixels;
    logic pixel_ready;

    logic shifter_msb;
    logic first_bit;
    logic last_bit;
    logic hold_full;

    ws2812b_pixel_shifter u_shifter (
        .clk        (clk),
        .reset      (reset),
        .load_first (load_first),
        .shift_en   (shift_en),
        .advance    (advance),
        .capture    (capture),
        .pixel_data (pixel_data),
        .msb        (shifter_msb),
        .first_bit  (first_bit),
        .last_bit   (last_bit),
        .hold_full  (hold_full)
    );

    // The period counter counts down from PERIOD_RELOAD; the reload value
    // marks the trigger cycle and zero marks the last cycle of the period.
    assign trigger     = (state == S_SHIFT) && (period_cnt == PERIOD_RELOAD);
    assign period_end  = (state == S_SHIFT) && (period_cnt == '0);
    assign more_pixels = (pixel_index != LAST_INDEX);
    assign pixel_ready = hold_full || (prefetch_req && pixel_valid);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        busy         = 1'b0;
        done         = 1'b0;
        pixel_req    = 1'b0;
        pixel_addr   = '0;
        bit_trigger  = 1'b0;
        bit_to_code  = 1'b0;
        start_accept = 1'b0;
        load_first   = 1'b0;
        shift_en     = 1'b0;
        advance      = 1'b0;
        capture      = 1'b0;
        enter_latch  = 1'b0;
        set_underrun = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    start_accept = 1'b1;
                    state_next   = S_FETCH0;
                end
            end

            S_FETCH0: begin
                busy      = 1'b1;
                pixel_req = 1'b1;
                if (pixel_valid) begin
                    load_first = 1'b1;
                    state_next = S_SHIFT;
                end
            end

            S_SHIFT: begin
                busy        = 1'b1;
                pixel_req   = prefetch_req;
                pixel_addr  = prefetch_req ? (pixel_index + ADDR_W'(1)) : '0;
                bit_trigger = trigger;
                bit_to_code = shifter_msb;
                capture     = prefetch_req && pixel_valid;
                // A handshake on the final edge of bit 23 still counts as in time.
                if (period_end) begin
                    if (!last_bit) begin
                        shift_en = 1'b1;
                    end else if (more_pixels && pixel_ready) begin
                        advance = 1'b1;
                    end else begin
                        set_underrun = more_pixels;
                        enter_latch  = 1'b1;
                        state_next   = S_LATCH;
                    end
                end
            end

            S_LATCH: begin
                busy = 1'b1;
                if (period_cnt == '0) begin
                    done       = 1'b1;
                    state_next = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // Frame bookkeeping: period/latch counter, pixel index, prefetch request,
    // sticky underrun flag and the line enable aligned to the encoder output.
    always_ff @(posedge clk) begin
        if (reset) begin
            period_cnt   <= '0;
            pixel_index  <= '0;
            prefetch_req <= 1'b0;
            underrun_q   <= 1'b0;
            line_en_q    <= 1'b0;
        end else begin
            line_en_q <= (state == S_SHIFT);

            if (start_accept) begin
                underrun_q <= 1'b0;
            end else if (set_underrun) begin
                underrun_q <= 1'b1;
            end

            if (load_first || advance || shift_en) begin
                period_cnt <= PERIOD_RELOAD;
            end else if (enter_latch) begin
                period_cnt <= LATCH_RELOAD;
            end else if (period_cnt != '0) begin
                period_cnt <= period_cnt - CNT_W'(1);
            end

            if (start_accept) begin
                pixel_index <= '0;
            end else if (advance) begin
                pixel_index <= pixel_index + ADDR_W'(1);
            end

            if (start_accept || enter_latch) begin
                prefetch_req <= 1'b0;
            end else if (trigger && first_bit && more_pixels) begin
                prefetch_req <= 1'b1;
            end else if (capture) begin
                prefetch_req <= 1'b0;
            end
        end
    end

    assign underrun = underrun_q;
    assign line_en  = line_en_q;

endmodule
